// File: rtl/ram_serial_responder.sv
// Multi-cycle byte/word responder for the pipeline data-memory port.
// Moves one byte per clock through a big-endian 2**ADDR_W x 8 array and pulses done on completion.
module ram_serial_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              E,
  input  logic              RW,
  input  logic              Size,
  input  logic [ADDR_W-1:0] Addd,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic              size_q;
  logic [31:0]       di_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_d;
  logic [31:0]       do_q;
  logic [1:0]        k_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]        Mem [0:2**ADDR_W-1];

  logic [ADDR_W-1:0] addr_cur;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;
  logic              last_beat;

  // Beat k touches addr+k; the ADDR_W-bit add gives the wrap past the top for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    addr_cur  = addr_q + ADDR_W'(k_q);
    rd_byte   = Mem[addr_cur];
    last_beat = !size_q || (k_q == 2'd3);
    wr_byte   = di_q[7:0];
    asm_d     = asm_q;
    if (size_q) begin
      case (k_q)
        2'd0: begin wr_byte = di_q[31:24]; asm_d[31:24] = rd_byte; end
        2'd1: begin wr_byte = di_q[23:16]; asm_d[23:16] = rd_byte; end
        2'd2: begin wr_byte = di_q[15:8];  asm_d[15:8]  = rd_byte; end
        default: begin wr_byte = di_q[7:0]; asm_d[7:0] = rd_byte; end
      endcase
    end
  end

  // NOTE: the storage array has no reset; R only gates the write so an aborted beat never lands.
  always_ff @(posedge clk) begin
    if (!R && state_q == XFER && rw_q) begin
      Mem[addr_cur] <= wr_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= 1'b0;
      di_q    <= '0;
      asm_q   <= '0;
      do_q    <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (E) begin
            state_q <= XFER;
            busy_q  <= 1'b1;
            addr_q  <= Addd;
            rw_q    <= RW;
            size_q  <= Size;
            di_q    <= DI;
            k_q     <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        XFER: begin
          asm_q <= asm_d;
          if (last_beat) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // DO changes only here, so a word read never exposes a partial value.
            if (!rw_q) begin
              do_q <= size_q ? asm_d : {24'b0, rd_byte};
            end
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DO   = do_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ram_serial_responder.sv
// Directed self-checking bench for ram_serial_responder: timing of busy/done, big-endian
// layout, address wrap, ignore-while-busy and reset abort.
module tb_ram_serial_responder;

  logic        clk = 1'b0;
  logic        R = 1'b1;
  logic        E = 1'b0;
  logic        RW = 1'b0;
  logic        Size = 1'b0;
  logic [7:0]  Addd = 8'd0;
  logic [31:0] DI = 32'd0;
  logic [31:0] DO;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  ram_serial_responder #(.ADDR_W(8)) dut (
    .clk  (clk),
    .R    (R),
    .E    (E),
    .RW   (RW),
    .Size (Size),
    .Addd (Addd),
    .DI   (DI),
    .DO   (DO),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic req(input logic rw, input logic size, input logic [7:0] a, input logic [31:0] d);
    E = 1'b1; RW = rw; Size = size; Addd = a; DI = d;
  endtask

  task automatic status(input string tag, input logic b, input logic d);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
  endtask

  int d0;

  initial begin
    dut.Mem[52] = 8'h80; dut.Mem[53] = 8'h00; dut.Mem[54] = 8'h00; dut.Mem[55] = 8'h05;
    dut.Mem[56] = 8'h12; dut.Mem[57] = 8'hFE; dut.Mem[59] = 8'h77;
    for (int i = 60; i < 64; i++) dut.Mem[i] = 8'h00;

    // Reset
    step(); step();
    R = 1'b0;
    status("reset", 1'b0, 1'b0);
    check("reset_do", DO, 32'h0);

    // Word read at 52: busy for 4 cycles, done in the 5th
    req(1'b0, 1'b1, 8'd52, 32'h0);
    step(); E = 1'b0;
    status("wr52_c1", 1'b1, 1'b0);
    check("wr52_do_hold", DO, 32'h0);
    step(); status("wr52_c2", 1'b1, 1'b0);
    step(); status("wr52_c3", 1'b1, 1'b0);
    step(); status("wr52_c4", 1'b1, 1'b0);
    step(); status("wr52_c5", 1'b0, 1'b1);
    check("wr52_do", DO, 32'h80000005);
    step(); status("wr52_idle", 1'b0, 1'b0);

    // Byte read 56, then byte read 57 issued in the done cycle
    req(1'b0, 1'b0, 8'd56, 32'h0);
    step(); E = 1'b0; status("br56_c1", 1'b1, 1'b0);
    step(); status("br56_c2", 1'b0, 1'b1);
    check("br56_do", DO, 32'h00000012);
    req(1'b0, 1'b0, 8'd57, 32'h0);
    step(); E = 1'b0; status("br57_c1", 1'b1, 1'b0);
    step(); status("br57_c2", 1'b0, 1'b1);
    check("br57_do", DO, 32'h000000FE);
    step();

    // Byte write isolation at 58
    req(1'b1, 1'b0, 8'd58, 32'hAABBCC34);
    step(); E = 1'b0; status("bw58_c1", 1'b1, 1'b0);
    step(); status("bw58_c2", 1'b0, 1'b1);
    check("bw58_do_kept", DO, 32'h000000FE);
    check("bw58_mem58", 32'(dut.Mem[58]), 32'h34);
    check("bw58_mem57", 32'(dut.Mem[57]), 32'hFE);
    check("bw58_mem59", 32'(dut.Mem[59]), 32'h77);
    step();

    // Word write wrapping past 255, then read it back back-to-back
    req(1'b1, 1'b1, 8'd254, 32'h11223344);
    step(); E = 1'b0;
    step(); step(); step();
    step(); status("ww254_fin", 1'b0, 1'b1);
    check("ww254_do_kept", DO, 32'h000000FE);
    check("ww254_m254", 32'(dut.Mem[254]), 32'h11);
    check("ww254_m255", 32'(dut.Mem[255]), 32'h22);
    check("ww254_m0", 32'(dut.Mem[0]), 32'h33);
    check("ww254_m1", 32'(dut.Mem[1]), 32'h44);
    req(1'b0, 1'b1, 8'd254, 32'h0);
    step(); E = 1'b0; status("rw254_c1", 1'b1, 1'b0);
    step(); step(); step();
    step(); status("rw254_fin", 1'b0, 1'b1);
    check("rw254_do", DO, 32'h11223344);
    step();

    // Ignore E while busy: byte write to 52 pulsed during beat 2
    d0 = done_seen;
    req(1'b0, 1'b1, 8'd52, 32'h0);
    step(); E = 1'b0;
    step();
    step(); req(1'b1, 1'b0, 8'd52, 32'h000000FF);
    step(); E = 1'b0; RW = 1'b0;
    step(); status("ign_fin", 1'b0, 1'b1);
    check("ign_do", DO, 32'h80000005);
    check("ign_mem52", 32'(dut.Mem[52]), 32'h80);
    step(); step(); step();
    status("ign_idle", 1'b0, 1'b0);
    check("ign_done_count", 32'(done_seen - d0), 32'd1);

    // Reset after two beats of a word write; R beats a simultaneous E
    req(1'b1, 1'b1, 8'd60, 32'hDEADBEEF);
    step(); E = 1'b0;
    step();
    step(); R = 1'b1; req(1'b0, 1'b0, 8'd60, 32'h0);
    step(); R = 1'b0;
    status("rst_after", 1'b0, 1'b0);
    check("rst_do", DO, 32'h0);
    check("rst_m60", 32'(dut.Mem[60]), 32'hDE);
    check("rst_m61", 32'(dut.Mem[61]), 32'hAD);
    check("rst_m62", 32'(dut.Mem[62]), 32'h00);
    check("rst_m63", 32'(dut.Mem[63]), 32'h00);
    // E is still high with a byte read at 60: must be accepted immediately
    step(); E = 1'b0; status("post_rst_c1", 1'b1, 1'b0);
    step(); status("post_rst_c2", 1'b0, 1'b1);
    check("post_rst_do", DO, 32'h000000DE);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
